// File: rtl/fp_norm_pipe.sv
// fp_norm_pipe -- two-stage post-add normaliser for the floating-point adder.
//
// Takes the raw sum from the adder core: a carry bit, a hidden bit and the
// fraction, plus the biased exponent. It produces a normalised mantissa and
// exponent for the rounder.
//   Stage 1 (classify): registers the operand and its leading-zero count.
//   Stage 2 (adjust):   applies the carry right shift or the leading-zero left
//                       shift. It also handles zero, overflow and denormals.
//
// Ports
//   clk_i, rst_ni        clock, synchronous active-low reset
//   valid_i / ready_o    input handshake
//   sign_i               sign, passed through
//   exponent_i [EXP_W]   biased exponent of the raw sum
//   mantissa_i [MAN_W+2] raw sum mantissa (MSB = carry, next = hidden)
//   valid_o / ready_i    output handshake
//   sign_o               registered sign
//   exponent_o, mantissa_o   normalised result
//   sticky_o             bit dropped by the carry right shift
//   zero_o, overflow_o, denorm_o   result classification flags
module fp_norm_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               valid_i,
   output logic               ready_o,
   input  logic               sign_i,
   input  logic [EXP_W-1:0]   exponent_i,
   input  logic [MAN_W+1:0]   mantissa_i,
   output logic               valid_o,
   input  logic               ready_i,
   output logic               sign_o,
   output logic [EXP_W-1:0]   exponent_o,
   output logic [MAN_W+1:0]   mantissa_o,
   output logic               sticky_o,
   output logic               zero_o,
   output logic               overflow_o,
   output logic               denorm_o
);

   localparam int LZ_W = $clog2(MAN_W + 2);
   // Exponent arithmetic width: one bit wider than the exponent, so that
   // exponent+1 and exponent-lz never wrap.
   localparam int CW   = (EXP_W + 1 > LZ_W) ? EXP_W + 1 : LZ_W;
   localparam logic [CW-1:0] EXP_MAX = {{(CW - EXP_W){1'b0}}, {EXP_W{1'b1}}};

   // Leading zeros from the hidden bit down to bit 0; all-zero gives MAN_W+1.
   function automatic logic [LZ_W-1:0] count_lz(input logic [MAN_W:0] m);
      logic [LZ_W-1:0] cnt;
      logic            found;
      cnt   = LZ_W'(MAN_W + 1);
      found = 1'b0;
      for (int i = MAN_W; i >= 0; i--) begin
         if (m[i] && !found) begin
            cnt   = LZ_W'(MAN_W - i);
            found = 1'b1;
         end
      end
      return cnt;
   endfunction

   // ---------------- stage 1 : classify ----------------
   logic               vld_p1_q, vld_p1_d;
   logic               sign_p1_q, sign_p1_d;
   logic [EXP_W-1:0]   exp_p1_q, exp_p1_d;
   logic [MAN_W+1:0]   man_p1_q, man_p1_d;
   logic [LZ_W-1:0]    lz_p1_q, lz_p1_d;

   logic               ready_p2;

   assign ready_p2 = !valid_o || ready_i;
   assign ready_o  = !vld_p1_q || ready_p2;

   always_comb begin
      vld_p1_d  = vld_p1_q;
      sign_p1_d = sign_p1_q;
      exp_p1_d  = exp_p1_q;
      man_p1_d  = man_p1_q;
      lz_p1_d   = lz_p1_q;
      if (ready_o) begin
         vld_p1_d = valid_i;
         if (valid_i) begin
            sign_p1_d = sign_i;
            exp_p1_d  = exponent_i;
            man_p1_d  = mantissa_i;
            lz_p1_d   = count_lz(mantissa_i[MAN_W:0]);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         vld_p1_q  <= 1'b0;
         sign_p1_q <= 1'b0;
         exp_p1_q  <= '0;
         man_p1_q  <= '0;
         lz_p1_q   <= '0;
      end else begin
         vld_p1_q  <= vld_p1_d;
         sign_p1_q <= sign_p1_d;
         exp_p1_q  <= exp_p1_d;
         man_p1_q  <= man_p1_d;
         lz_p1_q   <= lz_p1_d;
      end
   end

   // ---------------- stage 2 : adjust ----------------
   logic [CW-1:0]      exp_ext, lz_ext, shift_amt;
   logic [EXP_W-1:0]   n_exp;
   logic [MAN_W+1:0]   n_man;
   logic               n_sticky, n_zero, n_ovf, n_den;

   always_comb begin
      exp_ext   = CW'(exp_p1_q);
      lz_ext    = CW'(lz_p1_q);
      shift_amt = '0;
      n_exp     = '0;
      n_man     = '0;
      n_sticky  = 1'b0;
      n_zero    = 1'b0;
      n_ovf     = 1'b0;
      n_den     = 1'b0;
      if (man_p1_q == '0) begin
         n_zero = 1'b1;
      end else if (man_p1_q[MAN_W+1]) begin
         // The >= also catches an input exponent that is already all-ones.
         if (exp_ext + CW'(1) >= EXP_MAX) begin
            n_ovf = 1'b1;
            n_exp = '1;
         end else begin
            n_man    = man_p1_q >> 1;
            n_sticky = man_p1_q[0];
            n_exp    = EXP_W'(exp_ext + CW'(1));
         end
      end else if (man_p1_q[MAN_W]) begin
         n_man = man_p1_q;
         n_exp = exp_p1_q;
      end else if (lz_ext < exp_ext) begin
         n_man = man_p1_q << lz_p1_q;
         n_exp = EXP_W'(exp_ext - lz_ext);
      end else begin
         // Not enough exponent headroom: shift as far as the exponent allows
         // and emit a denormal.
         shift_amt = (exp_ext == '0) ? '0 : exp_ext - CW'(1);
         n_man     = man_p1_q << shift_amt;
         n_den     = 1'b1;
      end
   end

   logic               vld_p2_q, vld_p2_d;
   logic               sign_p2_q, sign_p2_d;
   logic [EXP_W-1:0]   exp_p2_q, exp_p2_d;
   logic [MAN_W+1:0]   man_p2_q, man_p2_d;
   logic               sticky_p2_q, sticky_p2_d;
   logic               zero_p2_q, zero_p2_d;
   logic               ovf_p2_q, ovf_p2_d;
   logic               den_p2_q, den_p2_d;

   always_comb begin
      vld_p2_d    = vld_p2_q;
      sign_p2_d   = sign_p2_q;
      exp_p2_d    = exp_p2_q;
      man_p2_d    = man_p2_q;
      sticky_p2_d = sticky_p2_q;
      zero_p2_d   = zero_p2_q;
      ovf_p2_d    = ovf_p2_q;
      den_p2_d    = den_p2_q;
      if (ready_p2) begin
         vld_p2_d = vld_p1_q;
         if (vld_p1_q) begin
            sign_p2_d   = sign_p1_q;
            exp_p2_d    = n_exp;
            man_p2_d    = n_man;
            sticky_p2_d = n_sticky;
            zero_p2_d   = n_zero;
            ovf_p2_d    = n_ovf;
            den_p2_d    = n_den;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         vld_p2_q    <= 1'b0;
         sign_p2_q   <= 1'b0;
         exp_p2_q    <= '0;
         man_p2_q    <= '0;
         sticky_p2_q <= 1'b0;
         zero_p2_q   <= 1'b0;
         ovf_p2_q    <= 1'b0;
         den_p2_q    <= 1'b0;
      end else begin
         vld_p2_q    <= vld_p2_d;
         sign_p2_q   <= sign_p2_d;
         exp_p2_q    <= exp_p2_d;
         man_p2_q    <= man_p2_d;
         sticky_p2_q <= sticky_p2_d;
         zero_p2_q   <= zero_p2_d;
         ovf_p2_q    <= ovf_p2_d;
         den_p2_q    <= den_p2_d;
      end
   end

   assign valid_o    = vld_p2_q;
   assign sign_o     = sign_p2_q;
   assign exponent_o = exp_p2_q;
   assign mantissa_o = man_p2_q;
   assign sticky_o   = sticky_p2_q;
   assign zero_o     = zero_p2_q;
   assign overflow_o = ovf_p2_q;
   assign denorm_o   = den_p2_q;

endmodule

// File: tb/tb_fp_norm_pipe.sv
module tb_fp_norm_pipe;
   localparam int EXP_W = 8;
   localparam int MAN_W = 23;

   typedef struct packed {
      logic        s;
      logic [7:0]  e;
      logic [24:0] m;
      logic        st;
      logic        z;
      logic        o;
      logic        d;
   } res_t;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        valid_i, ready_o, sign_i, valid_o, ready_i, sign_o;
   logic [7:0]  exponent_i, exponent_o;
   logic [24:0] mantissa_i, mantissa_o;
   logic        sticky_o, zero_o, overflow_o, denorm_o;
   res_t        dut_r;

   fp_norm_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .valid_i(valid_i), .ready_o(ready_o),
      .sign_i(sign_i), .exponent_i(exponent_i), .mantissa_i(mantissa_i),
      .valid_o(valid_o), .ready_i(ready_i),
      .sign_o(sign_o), .exponent_o(exponent_o), .mantissa_o(mantissa_o),
      .sticky_o(sticky_o), .zero_o(zero_o), .overflow_o(overflow_o),
      .denorm_o(denorm_o)
   );

   always #5 clk = ~clk;

   assign dut_r = {sign_o, exponent_o, mantissa_o, sticky_o, zero_o, overflow_o, denorm_o};

   int   checks = 0;
   int   errors = 0;
   res_t exp_q[$];

   // Result rules written directly from the normaliser's behaviour, in plain integers.
   function automatic res_t model(input logic s, input logic [7:0] e, input logic [24:0] m);
      res_t r;
      int   ei, top, lz, sh;
      r    = '0;
      r.s  = s;
      ei   = int'(e);
      if (m == 25'd0) begin
         r.z = 1'b1;
      end else if (m[24]) begin
         if (ei + 1 >= 255) begin
            r.o = 1'b1;
            r.e = 8'hFF;
         end else begin
            r.e  = 8'(ei + 1);
            r.m  = m >> 1;
            r.st = m[0];
         end
      end else if (m[23]) begin
         r.e = e;
         r.m = m;
      end else begin
         top = 0;
         for (int i = 0; i < 24; i++) if (m[i]) top = i;
         lz = 23 - top;
         if (lz < ei) begin
            r.m = m << lz;
            r.e = 8'(ei - lz);
         end else begin
            sh  = (ei == 0) ? 0 : ei - 1;
            r.m = m << sh;
            r.d = 1'b1;
         end
      end
      return r;
   endfunction

   function automatic res_t mk(input logic s, input logic [7:0] e, input logic [24:0] m,
                               input logic st, input logic z, input logic o, input logic d);
      res_t r;
      r = {s, e, m, st, z, o, d};
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Scoreboard: checks every presented result; reset discards everything in flight.
   always @(negedge clk) begin
      if (!rst_ni) begin
         exp_q.delete();
      end else begin
         if (valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got %0h with nothing outstanding", dut_r);
            end else begin
               check("stream_result", 64'(dut_r), 64'(exp_q[0]));
               if (ready_i) void'(exp_q.pop_front());
            end
         end
         if (valid_i && ready_o) exp_q.push_back(model(sign_i, exponent_i, mantissa_i));
      end
   end

   // Presents one operand; returns at posedge+1 just after it was accepted.
   task automatic drive(input logic s, input logic [7:0] e, input logic [24:0] m);
      logic acc;
      int   n;
      sign_i = s; exponent_i = e; mantissa_i = m; valid_i = 1'b1;
      n = 0;
      acc = 1'b0;
      do begin
         @(negedge clk);
         acc = ready_o;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 50);
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: ready_o stayed %0b, required 1", ready_o);
      end
      valid_i = 1'b0;
   endtask

   task automatic directed(input string name, input logic s, input logic [7:0] e,
                           input logic [24:0] m, input res_t req);
      ready_i = 1'b1;
      check({name, "_model"}, 64'(model(s, e, m)), 64'(req));
      drive(s, e, m);
      @(posedge clk);
      #1;
      check({name, "_valid"}, 64'(valid_o), 64'd1);
      check(name, 64'(dut_r), 64'(req));
      @(posedge clk);
      #1;
   endtask

   task automatic drain;
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
      end
   endtask

   initial begin
      rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
      sign_i = 1'b0; exponent_i = '0; mantissa_i = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_valid", 64'(valid_o), 64'd0);
      check("reset_outputs", 64'(dut_r), 64'd0);
      rst_ni = 1'b1;
      check("reset_ready", 64'(ready_o), 64'd1);

      directed("lz_shift",   1'b0, 8'h80, 25'h0000010, mk(0, 8'h6D, 25'h0800000, 0, 0, 0, 0));
      directed("carry",      1'b1, 8'h7F, 25'h1800001, mk(1, 8'h80, 25'h0C00000, 1, 0, 0, 0));
      directed("overflow",   1'b0, 8'hFE, 25'h1000000, mk(0, 8'hFF, 25'h0000000, 0, 0, 1, 0));
      directed("zero",       1'b1, 8'h55, 25'h0000000, mk(1, 8'h00, 25'h0000000, 0, 1, 0, 0));
      directed("denorm",     1'b0, 8'h03, 25'h0000100, mk(0, 8'h00, 25'h0000400, 0, 0, 0, 1));
      directed("denorm_e0",  1'b0, 8'h00, 25'h0000001, mk(0, 8'h00, 25'h0000001, 0, 0, 0, 1));
      directed("ovf_at_ff",  1'b0, 8'hFF, 25'h1000002, mk(0, 8'hFF, 25'h0000000, 0, 0, 1, 0));
      directed("carry_fd",   1'b0, 8'hFD, 25'h1000001, mk(0, 8'hFE, 25'h0800000, 1, 0, 0, 0));
      directed("hidden",     1'b1, 8'h40, 25'h0ABCDEF, mk(1, 8'h40, 25'h0ABCDEF, 0, 0, 0, 0));
      directed("lz_eq_exp",  1'b0, 8'h0F, 25'h0000100, mk(0, 8'h00, 25'h0400000, 0, 0, 0, 1));
      directed("lz_lt_exp",  1'b0, 8'h10, 25'h0000100, mk(0, 8'h01, 25'h0800000, 0, 0, 0, 0));

      // Backpressure: four back-to-back operands, ready_i low for three cycles.
      ready_i = 1'b0;
      fork
         begin
            drive(1'b0, 8'h80, 25'h0000010);
            drive(1'b1, 8'h7F, 25'h1800001);
            drive(1'b0, 8'h20, 25'h0001234);
            drive(1'b1, 8'h02, 25'h0000003);
         end
         begin
            @(posedge clk);
            @(posedge clk);
            #1;
            check("bp_ready_low", 64'(ready_o), 64'd0);
            check("bp_head", 64'(dut_r), 64'(mk(0, 8'h6D, 25'h0800000, 0, 0, 0, 0)));
            @(posedge clk);
            #1;
            check("bp_hold_valid", 64'(valid_o), 64'd1);
            check("bp_hold", 64'(dut_r), 64'(mk(0, 8'h6D, 25'h0800000, 0, 0, 0, 0)));
            #1;
            ready_i = 1'b1;
         end
      join
      drain();

      // Reset mid-stream with both stages full.
      ready_i = 1'b0;
      drive(1'b1, 8'h90, 25'h0000040);
      drive(1'b0, 8'h10, 25'h1000001);
      check("pre_reset_ready", 64'(ready_o), 64'd0);
      rst_ni = 1'b0;
      @(posedge clk);
      #1;
      check("mid_reset_valid", 64'(valid_o), 64'd0);
      check("mid_reset_outputs", 64'(dut_r), 64'd0);
      check("mid_reset_ready", 64'(ready_o), 64'd1);
      rst_ni  = 1'b1;
      ready_i = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("post_reset_idle", 64'(valid_o), 64'd0);

      directed("after_reset", 1'b1, 8'h80, 25'h0000010, mk(1, 8'h6D, 25'h0800000, 0, 0, 0, 0));
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fp_norm_pipe.md
Name: fp_norm_pipe

Overview:
- Parametrised, pipelined post-add normaliser for the floating-point adder datapath.
- Takes the raw sum mantissa (carry bit, hidden bit, fraction) and biased exponent from the adder core and produces a normalised mantissa and exponent.
- Handles carry-out right shift, leading-zero left shift of any length, zero results, exponent overflow and underflow to denormal.
- Two-stage valid/ready pipeline, throughput one result per cycle; sits between the adder core and the rounder.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, fraction width; mantissa buses are MAN_W+2 bits (bit MAN_W+1 = carry, bit MAN_W = hidden)

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
valid_i  in  1  input operand valid
ready_o  out  1  block can accept an operand this cycle
sign_i  in  1  sign, passed through unchanged
exponent_i  in  EXP_W  biased exponent of the raw sum
mantissa_i  in  MAN_W+2  raw sum mantissa
valid_o  out  1  result valid
ready_i  in  1  downstream accepts the result
sign_o  out  1  registered sign
exponent_o  out  EXP_W  normalised exponent
mantissa_o  out  MAN_W+2  normalised mantissa; bit MAN_W+1 is always 0
sticky_o  out  1  bit lost by the carry right shift
zero_o  out  1  mantissa_i was all zero
overflow_o  out  1  exponent saturated to all-ones (infinity)
denorm_o  out  1  result is denormal (exponent_o = 0)

Behaviour:
- Reset: clk_i/rst_ni is one clock with a synchronous, active-low reset. While rst_ni = 0 at a rising edge, both stage valids and every output clear to 0. Reset mid-operation discards in-flight data; ready_o is 1 in the first cycle after reset.
- Handshake: a transfer occurs when valid and ready are both high. Per stage, stage_ready = !stage_valid || next_ready; ready_o is stage 1's stage_ready. A held result keeps every output stable while valid_o=1 and ready_i=0.
- Latency: 2 cycles from input handshake to valid_o with no stall. Results leave in input order; no drops, no duplicates.
- Stage 1 (classify): register the inputs plus lz, the count of leading zeros from bit MAN_W down to bit 0. lz width is $clog2(MAN_W+2); lz = MAN_W+1 when all bits are zero.
- Stage 2 (adjust), with priority:
  1. mantissa == 0: zero_o=1, exponent_o=0, mantissa_o=0.
  2. Carry bit set: mantissa_o = mantissa >> 1, sticky_o = old bit 0, exponent_o = exponent+1.
     - If exponent+1 equals all-ones: overflow_o=1, exponent_o = all-ones, mantissa_o=0, sticky_o=0.
     - An input exponent already at all-ones with carry set also gives overflow.
  3. Hidden bit set: pass through unchanged.
  4. lz < exponent (unsigned, zero-extended to a common width): mantissa << lz, exponent_o = exponent - lz.
  5. Otherwise (underflow): shift = (exponent==0) ? 0 : exponent-1; mantissa << shift, exponent_o=0, denorm_o=1.
- In every case the output is fully defined; no latched values. Flags not named in a case are 0, and sticky_o=0 outside case 2.
- Exponent arithmetic is done in EXP_W+1 bits; the result never wraps.

Test Plan:
- Leading-zero shift: exp=0x80, mant=25'h000010, ready_i=1 → 2 cycles later exp=0x6D, mant=25'h800000, all flags 0.
- Carry shift: exp=0x7F, mant=25'h1800001 → exp=0x80, mant=25'hC00000, sticky_o=1.
- Overflow and zero:
  - exp=0xFE, mant=25'h1000000 → exp=0xFF, mant=0, overflow_o=1.
  - exp=0x55, mant=0 → zero_o=1, exp=0, mant=0.
- Denormal: exp=0x03, mant=25'h000100 (lz=15) → shift 2, exp=0, mant=25'h000400, denorm_o=1. Also exp=0x00, mant=25'h000001 → unshifted, denorm_o=1.
- Backpressure: stream 4 back-to-back operands with ready_i=0 for 3 cycles → ready_o falls after 2 accepted. Outputs stay stable while held; all 4 results emerge in order once ready_i=1.
- Reset mid-stream: drop rst_ni for one cycle with both stages valid → valid_o=0 and all outputs 0 next cycle, ready_o=1; nothing from before the reset is ever emitted.
